// File: rtl/quad_pkg.sv
// Shared widths, result-status encodings and controller states for the
// quadratic discriminant / integer square-root block.
package quad_pkg;

   localparam int W_IN_DEF   = 16;
   localparam int W_DISC_DEF = 2*W_IN_DEF + 2;
   localparam int W_ROOT_DEF = W_IN_DEF + 1;

   localparam logic [1:0] ST_NONE   = 2'd0;
   localparam logic [1:0] ST_DOUBLE = 2'd1;
   localparam logic [1:0] ST_TWO    = 2'd2;
   localparam logic [1:0] ST_DEGEN  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_ROOT,
      S_DONE
   } state_t;

endpackage

// File: rtl/quad_isqrt.sv
// Restoring bit-pair integer square root, one root bit per clock.
// done_o flags the final iteration; root_o/rem_o carry the values that iteration produces.
module quad_isqrt #(
   parameter int W_ROOT = quad_pkg::W_ROOT_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [2*W_ROOT-1:0]   radicand_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [W_ROOT-1:0]     root_o,
   output logic [W_ROOT+3:0]     rem_o
);

   localparam int RW = W_ROOT + 2;
   localparam int CW = $clog2(W_ROOT);
   localparam logic [CW-1:0] LAST = CW'(W_ROOT - 1);

   logic [2*W_ROOT-1:0] rad_q;
   logic [W_ROOT-1:0]   root_q;
   logic [RW-1:0]       rem_q;
   logic [CW-1:0]       cnt_q;
   logic                busy_q;

   logic [RW+1:0]       rem_t;
   logic [RW+1:0]       trial;
   logic [RW+1:0]       rem_n;
   logic [W_ROOT-1:0]   root_n;

   // Bring down the next radicand bit pair and try subtracting 4*root+1.
   always_comb begin
      rem_t  = {rem_q, rad_q[2*W_ROOT-1 -: 2]};
      trial  = {2'b00, root_q, 2'b01};
      rem_n  = rem_t;
      root_n = {root_q[W_ROOT-2:0], 1'b0};
      if (rem_t >= trial) begin
         rem_n  = rem_t - trial;
         root_n = {root_q[W_ROOT-2:0], 1'b1};
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == LAST);
   assign root_o = root_n;
   assign rem_o  = rem_n;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rad_q  <= '0;
         root_q <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         rad_q  <= radicand_i;
         root_q <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         rad_q  <= {rad_q[2*W_ROOT-3:0], 2'b00};
         root_q <= root_n;
         rem_q  <= rem_n[RW-1:0];
         cnt_q  <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/quad_disc_root.sv
// Computes b*b-4*a*c at full precision, classifies the roots and, for a
// positive discriminant, its integer square root via quad_isqrt.
module quad_disc_root
   import quad_pkg::*;
#(
   parameter int W_IN   = W_IN_DEF,
   parameter int W_DISC = 2*W_IN + 2,
   parameter int W_ROOT = W_IN + 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     START,
   input  logic signed [W_IN-1:0]   A,
   input  logic signed [W_IN-1:0]   B,
   input  logic signed [W_IN-1:0]   C,
   output logic                     BUSY,
   output logic                     DONE,
   output logic signed [W_DISC-1:0] DISC,
   output logic        [W_ROOT-1:0] SQRT,
   output logic                     EXACT,
   output logic        [1:0]        ST
);

   state_t                   state_q, state_d;
   logic signed [W_IN-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic signed [W_DISC-1:0] dwork_q, dwork_d;
   logic signed [W_DISC-1:0] disc_q, disc_d;
   logic        [W_ROOT-1:0] sqrt_q, sqrt_d;
   logic                     exact_q, exact_d;
   logic        [1:0]        st_q, st_d;

   logic signed [W_DISC-1:0] aa, bb, cc, disc_full;
   logic                     root_start, root_busy, root_done;
   logic        [W_ROOT-1:0] root_val;
   logic        [W_ROOT+3:0] root_rem;

   // Operands are widened before multiplying so neither product nor difference can wrap.
   assign aa        = {{(W_DISC-W_IN){a_q[W_IN-1]}}, a_q};
   assign bb        = {{(W_DISC-W_IN){b_q[W_IN-1]}}, b_q};
   assign cc        = {{(W_DISC-W_IN){c_q[W_IN-1]}}, c_q};
   assign disc_full = bb*bb - ((aa*cc) <<< 2);

   quad_isqrt #(.W_ROOT(W_ROOT)) u_isqrt (
      .clk_i      (CLK),
      .rst_i      (RST),
      .start_i    (root_start),
      .radicand_i (disc_full),
      .busy_o     (root_busy),
      .done_o     (root_done),
      .root_o     (root_val),
      .rem_o      (root_rem)
   );

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      dwork_d    = dwork_q;
      disc_d     = disc_q;
      sqrt_d     = sqrt_q;
      exact_d    = exact_q;
      st_d       = st_q;
      root_start = 1'b0;
      case (state_q)
         S_IDLE: if (START) begin
            a_d     = A;
            b_d     = B;
            c_d     = C;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            dwork_d = disc_full;
            if (a_q == '0) begin
               {disc_d, sqrt_d, exact_d, st_d} = {disc_full, {W_ROOT{1'b0}}, 1'b0, ST_DEGEN};
               state_d = S_DONE;
            end else if (disc_full[W_DISC-1]) begin
               {disc_d, sqrt_d, exact_d, st_d} = {disc_full, {W_ROOT{1'b0}}, 1'b0, ST_NONE};
               state_d = S_DONE;
            end else if (disc_full == '0) begin
               {disc_d, sqrt_d, exact_d, st_d} = {disc_full, {W_ROOT{1'b0}}, 1'b1, ST_DOUBLE};
               state_d = S_DONE;
            end else begin
               root_start = 1'b1;
               state_d    = S_ROOT;
            end
         end
         S_ROOT: if (root_done) begin
            disc_d  = dwork_q;
            sqrt_d  = root_val;
            exact_d = (root_rem == '0);
            st_d    = ST_TWO;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         dwork_q <= '0;
         disc_q  <= '0;
         sqrt_q  <= '0;
         exact_q <= 1'b0;
         st_q    <= ST_NONE;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         dwork_q <= dwork_d;
         disc_q  <= disc_d;
         sqrt_q  <= sqrt_d;
         exact_q <= exact_d;
         st_q    <= st_d;
      end
   end

   assign BUSY  = (state_q != S_IDLE) || root_busy;
   assign DONE  = (state_q == S_DONE);
   assign DISC  = disc_q;
   assign SQRT  = sqrt_q;
   assign EXACT = exact_q;
   assign ST    = st_q;

endmodule

// File: tb/tb_quad_disc_root.sv
// Directed checks of quad_disc_root: classification, latency, square root,
// result holding, START handling and reset abort.
module tb_quad_disc_root;

   logic               CLK;
   logic               RST;
   logic               START;
   logic signed [15:0] A, B, C;
   logic               BUSY, DONE;
   logic signed [33:0] DISC;
   logic        [16:0] SQRT;
   logic               EXACT;
   logic        [1:0]  ST;

   int     n_cmp = 0;
   int     n_err = 0;
   longint prev_disc = 0;

   quad_disc_root dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .C     (C),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .DISC  (DISC),
      .SQRT  (SQRT),
      .EXACT (EXACT),
      .ST    (ST)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_ops(input int a, input int b, input int c);
      A = 16'(a);
      B = 16'(b);
      C = 16'(c);
   endtask

   task automatic check_results(input string tag, input longint disc, input int sq,
                                input int ex, input int st);
      check({tag, ".disc"},  longint'(DISC),  disc);
      check({tag, ".sqrt"},  longint'(SQRT),  longint'(sq));
      check({tag, ".exact"}, longint'(EXACT), longint'(ex));
      check({tag, ".st"},    longint'(ST),    longint'(st));
   endtask

   // Pulse START for one cycle and wait (bounded) for the DONE pulse.
   task automatic run_op(input string tag, input int a, input int b, input int c,
                         input int lat, input longint disc, input int sq,
                         input int ex, input int st);
      int n;
      bit seen;
      START = 1'b1;
      set_ops(a, b, c);
      tick();
      START = 1'b0;
      set_ops(-1, 1, -1);
      check({tag, ".busy"}, longint'(BUSY), 1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         if (lat > 1 && n == 1) check({tag, ".hold"}, longint'(DISC), prev_disc);
         if (DONE) seen = 1'b1;
      end
      check({tag, ".done_seen"}, longint'(seen), 1);
      check({tag, ".latency"}, longint'(n), longint'(lat));
      check_results(tag, disc, sq, ex, st);
      tick();
      check({tag, ".pulse"}, longint'(DONE), 0);
      check({tag, ".idle"},  longint'(BUSY), 0);
      prev_disc = disc;
   endtask

   initial begin
      int n;
      int dones;
      bit seen;

      RST   = 1'b1;
      START = 1'b0;
      set_ops(0, 0, 0);
      tick();
      tick();
      check("rst.busy", longint'(BUSY), 0);
      check("rst.done", longint'(DONE), 0);
      check_results("rst", 0, 0, 0, 0);
      RST = 1'b0;
      tick();

      run_op("double",   1,  -2,    1,  1,  0,   0, 1, 1);
      run_op("none",     1,  -2,    3,  1, -8,   0, 0, 0);
      run_op("degen",    0,   5,    1,  1, 25,   0, 0, 3);
      run_op("two_ex",   1,  -2,   -3, 18, 16,   4, 1, 2);
      run_op("two_inex", 3, -47, -170, 18, 4249, 65, 0, 2);
      run_op("extreme", -32768, -32768, 32767, 18, 64'sd5368578048, 73270, 0, 2);

      // Reset in the middle of a root computation must abort without DONE.
      START = 1'b1;
      set_ops(1, -2, -3);
      tick();
      START = 1'b0;
      repeat (4) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort.busy", longint'(BUSY), 0);
      check("abort.done", longint'(DONE), 0);
      check_results("abort", 0, 0, 0, 0);
      dones = 0;
      repeat (25) begin
         tick();
         if (DONE) dones++;
      end
      check("abort.no_done", longint'(dones), 0);
      prev_disc = 0;

      run_op("neg_min", -32768, 0, -32768, 1, -64'sd4294967296, 0, 0, 0);

      // START held high: operands change every cycle but only the IDLE sample counts.
      START = 1'b1;
      set_ops(1, -2, -3);
      tick();
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         set_ops(7 + n, 9 - n, -100 + 3*n);
         tick();
         n++;
         if (DONE) seen = 1'b1;
      end
      check("held.done_seen", longint'(seen), 1);
      check("held.latency", longint'(n), 18);
      check_results("held", 16, 4, 1, 2);
      set_ops(1, -2, 1);
      tick();
      check("held.no_b2b_done", longint'(DONE), 0);
      check("held.no_b2b_busy", longint'(BUSY), 0);
      tick();
      check("held.accept", longint'(BUSY), 1);
      START = 1'b0;
      set_ops(5, 5, 5);
      tick();
      check("held2.done", longint'(DONE), 1);
      check_results("held2", 0, 0, 1, 1);
      tick();

      // Reset wins over a simultaneous START.
      RST   = 1'b1;
      START = 1'b1;
      set_ops(1, -2, -3);
      tick();
      check("prio.busy", longint'(BUSY), 0);
      check("prio.st", longint'(ST), 0);
      RST   = 1'b0;
      START = 1'b0;
      tick();
      check("prio.idle", longint'(BUSY), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
